// File: rtl/inst_fetch_port.sv
// Instruction-side SRAM-like bus port: in-order in-flight fetch queue with
// per-entry PC/exception tagging, flush-by-discard, and registered responses.
module inst_fetch_port #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              tlb_found,
  input  logic              tlb_v,
  input  logic              flush,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_pc,
  output logic [DATA_W-1:0] resp_instr,
  output logic [2:0]        resp_exc,
  output logic              busy,
  output logic              proto_err,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_wdata,
  input  logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]    q_pc  [MAX_OUTST];
  logic [2:0]           q_exc [MAX_OUTST];
  logic [MAX_OUTST-1:0] q_bus;
  logic [MAX_OUTST-1:0] q_discard;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 exc_in_q;

  logic [2:0] fetch_exc;
  logic       q_empty;
  logic       q_full;
  logic       bus_push;
  logic       exc_push;
  logic       push;
  logic       head_bus;
  logic       bus_pop;
  logic       exc_pop;
  logic       pop;
  logic       pop_discard;

  // Exception classification: misalignment outranks any TLB result.
  always_comb begin
    fetch_exc = 3'b000;
    if (fetch_pc[1:0] != 2'b00) begin
      fetch_exc = 3'b100;
    end else if (!tlb_found) begin
      fetch_exc = 3'b010;
    end else if (!tlb_v) begin
      fetch_exc = 3'b001;
    end
  end

  always_comb begin
    q_empty  = (count == '0);
    q_full   = (count == CNT_W'(MAX_OUTST));
    head_bus = q_bus[rd_ptr];

    inst_req = fetch_valid & (fetch_exc == 3'b000) & !q_full & !flush & !exc_in_q;
    bus_push = inst_req & inst_addr_ok;
    // Exception fetches only enter an empty queue so they can never overtake a bus fetch.
    exc_push = fetch_valid & (fetch_exc != 3'b000) & q_empty & !flush;
    push     = bus_push | exc_push;

    bus_pop  = inst_data_ok & !q_empty & head_bus;
    exc_pop  = !q_empty & !head_bus;
    pop      = bus_pop | exc_pop;

    // An entry popping in the flush cycle is discarded as well.
    pop_discard = q_discard[rd_ptr] | flush;

    fetch_ready = push;
    busy        = !q_empty;
  end

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_addr  = fetch_pc;
  assign inst_wdata = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      exc_in_q  <= 1'b0;
      q_bus     <= '0;
      q_discard <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        q_pc[i]  <= '0;
        q_exc[i] <= 3'b000;
      end
    end else begin
      if (flush) begin
        q_discard <= '1;
      end
      if (push) begin
        q_pc[wr_ptr]      <= fetch_pc;
        q_exc[wr_ptr]     <= fetch_exc;
        q_bus[wr_ptr]     <= bus_push;
        q_discard[wr_ptr] <= 1'b0;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (exc_push) begin
        exc_in_q <= 1'b1;
      end else if (exc_pop) begin
        exc_in_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_pc    <= '0;
      resp_instr <= '0;
      resp_exc   <= 3'b000;
      proto_err  <= 1'b0;
    end else begin
      resp_valid <= pop & !pop_discard;
      if (pop && !pop_discard) begin
        resp_pc    <= q_pc[rd_ptr];
        resp_instr <= head_bus ? inst_rdata : '0;
        resp_exc   <= q_exc[rd_ptr];
      end
      // A data beat that does not match a bus entry at the head is a bridge fault.
      if (inst_data_ok && !bus_pop) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Directed self-checking bench for inst_fetch_port: reset, pipelining, full,
// flush, exception tagging/ordering and stray data_ok handling.
module tb_inst_fetch_port;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        tlb_found;
  logic        tlb_v;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic [31:0] resp_instr;
  logic [2:0]  resp_exc;
  logic        busy;
  logic        proto_err;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  int n_pass;
  int n_total;

  inst_fetch_port #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .tlb_found(tlb_found), .tlb_v(tlb_v), .flush(flush),
    .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_instr(resp_instr), .resp_exc(resp_exc),
    .busy(busy), .proto_err(proto_err),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [2:0] exc);
    chk({tag, "_valid"}, 64'(resp_valid), 64'(1'b1));
    chk({tag, "_pc"}, 64'(resp_pc), 64'(pc));
    chk({tag, "_instr"}, 64'(resp_instr), 64'(instr));
    chk({tag, "_exc"}, 64'(resp_exc), 64'(exc));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    fetch_valid = 1'b0;
    fetch_pc = 32'h0;
    tlb_found = 1'b1;
    tlb_v = 1'b1;
    flush = 1'b0;
    inst_rdata = 32'h0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'(1'b0));
    chk("rst_resp_pc", 64'(resp_pc), 64'(32'h0));
    chk("rst_resp_instr", 64'(resp_instr), 64'(32'h0));
    chk("rst_resp_exc", 64'(resp_exc), 64'(3'b000));
    chk("rst_proto_err", 64'(proto_err), 64'(1'b0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("const_wr", 64'(inst_wr), 64'(1'b0));
    chk("const_size", 64'(inst_size), 64'(2'b10));
    chk("const_wdata", 64'(inst_wdata), 64'(32'h0));

    // Stray data_ok on an empty queue
    inst_data_ok = 1'b1;
    inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("proto_err_set", 64'(proto_err), 64'(1'b1));
    chk("proto_busy", 64'(busy), 64'(1'b0));
    chk("proto_no_resp", 64'(resp_valid), 64'(1'b0));
    tick();
    chk("proto_sticky", 64'(proto_err), 64'(1'b1));

    // Mid-stream reset
    fetch_valid = 1'b1;
    fetch_pc = 32'h2000;
    inst_addr_ok = 1'b1;
    #1;
    chk("r1_inst_req", 64'(inst_req), 64'(1'b1));
    chk("r1_inst_addr", 64'(inst_addr), 64'(32'h2000));
    tick();
    fetch_valid = 1'b0;
    inst_addr_ok = 1'b0;
    #1;
    chk("r1_busy_before", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("r1_busy_async", 64'(busy), 64'(1'b0));
    chk("r1_proto_clr", 64'(proto_err), 64'(1'b0));
    chk("r1_resp_valid", 64'(resp_valid), 64'(1'b0));
    tick();
    rst = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc = 32'h3000;
    #1;
    chk("r1_req_follows1", 64'(inst_req), 64'(1'b1));
    fetch_valid = 1'b0;
    #1;
    chk("r1_req_follows0", 64'(inst_req), 64'(1'b0));
    tick();

    // Pipelined fetches, data two cycles after each accept
    fetch_valid = 1'b1;
    inst_addr_ok = 1'b1;
    fetch_pc = 32'h1000;
    #1;
    chk("p_ready0", 64'(fetch_ready), 64'(1'b1));
    tick();
    fetch_pc = 32'h1004;
    tick();
    fetch_pc = 32'h1008;
    inst_data_ok = 1'b1;
    inst_rdata = 32'hA000_0000;
    #1;
    chk("p_no_resp_yet", 64'(resp_valid), 64'(1'b0));
    tick();
    fetch_pc = 32'h100C;
    inst_rdata = 32'hA000_0001;
    chk_resp("p_r0", 32'h1000, 32'hA000_0000, 3'b000);
    tick();
    fetch_valid = 1'b0;
    inst_addr_ok = 1'b0;
    inst_rdata = 32'hA000_0002;
    chk_resp("p_r1", 32'h1004, 32'hA000_0001, 3'b000);
    tick();
    inst_rdata = 32'hA000_0003;
    chk_resp("p_r2", 32'h1008, 32'hA000_0002, 3'b000);
    tick();
    inst_data_ok = 1'b0;
    chk_resp("p_r3", 32'h100C, 32'hA000_0003, 3'b000);
    chk("p_busy_end", 64'(busy), 64'(1'b0));
    tick();
    chk("p_resp_drop", 64'(resp_valid), 64'(1'b0));

    // Full queue
    fetch_valid = 1'b1;
    inst_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_pc = 32'h4000 + 32'(4 * i);
      tick();
    end
    fetch_pc = 32'h4010;
    #1;
    chk("f_ready_full", 64'(fetch_ready), 64'(1'b0));
    chk("f_req_full", 64'(inst_req), 64'(1'b0));
    chk("f_busy", 64'(busy), 64'(1'b1));
    inst_data_ok = 1'b1;
    inst_rdata = 32'hB000_0000;
    #1;
    chk("f_no_comb_path", 64'(fetch_ready), 64'(1'b0));
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("f_req_resume", 64'(inst_req), 64'(1'b1));
    chk("f_ready_resume", 64'(fetch_ready), 64'(1'b1));
    chk_resp("f_r0", 32'h4000, 32'hB000_0000, 3'b000);
    tick();
    fetch_valid = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_rdata = 32'hB000_0001 + 32'(i);
      tick();
      chk("f_drain_pc", 64'(resp_pc), 64'(32'h4004 + 32'(4 * i)));
      chk("f_drain_instr", 64'(resp_instr), 64'(32'hB000_0001 + 32'(i)));
    end
    inst_data_ok = 1'b0;
    #1;
    chk("f_busy_end", 64'(busy), 64'(1'b0));

    // Flush with three in flight
    fetch_valid = 1'b1;
    inst_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'h5000 + 32'(4 * i);
      tick();
    end
    fetch_pc = 32'hBFC0_0380;
    flush = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata = 32'hC000_0000;
    #1;
    chk("fl_req_blocked", 64'(inst_req), 64'(1'b0));
    chk("fl_ready_blocked", 64'(fetch_ready), 64'(1'b0));
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    inst_addr_ok = 1'b0;
    chk("fl_sup0", 64'(resp_valid), 64'(1'b0));
    tick();
    chk("fl_sup1", 64'(resp_valid), 64'(1'b0));
    tick();
    inst_data_ok = 1'b0;
    chk("fl_sup2", 64'(resp_valid), 64'(1'b0));
    chk("fl_busy", 64'(busy), 64'(1'b0));
    chk("fl_proto_ok", 64'(proto_err), 64'(1'b0));
    fetch_valid = 1'b1;
    inst_addr_ok = 1'b1;
    tick();
    fetch_valid = 1'b0;
    inst_addr_ok = 1'b0;
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'hC000_0380;
    tick();
    inst_data_ok = 1'b0;
    chk_resp("fl_after", 32'hBFC0_0380, 32'hC000_0380, 3'b000);

    // Exceptions: adel beats refill, then refill, then invalid
    fetch_valid = 1'b1;
    fetch_pc = 32'h1002;
    tlb_found = 1'b0;
    inst_addr_ok = 1'b1;
    #1;
    chk("e_adel_noreq", 64'(inst_req), 64'(1'b0));
    chk("e_adel_ready", 64'(fetch_ready), 64'(1'b1));
    tick();
    fetch_valid = 1'b0;
    chk("e_adel_busy", 64'(busy), 64'(1'b1));
    tick();
    chk_resp("e_adel", 32'h1002, 32'h0, 3'b100);
    fetch_valid = 1'b1;
    fetch_pc = 32'h6000;
    tick();
    fetch_valid = 1'b0;
    tick();
    chk_resp("e_refill", 32'h6000, 32'h0, 3'b010);
    tlb_found = 1'b1;
    tlb_v = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc = 32'h6004;
    #1;
    chk("e_inv_noreq", 64'(inst_req), 64'(1'b0));
    tick();
    fetch_valid = 1'b0;
    tick();
    chk_resp("e_invalid", 32'h6004, 32'h0, 3'b001);
    tlb_v = 1'b1;

    // Exception fetch waits behind an older bus fetch
    fetch_valid = 1'b1;
    fetch_pc = 32'h7000;
    tick();
    fetch_pc = 32'h7002;
    #1;
    chk("o_wait_ready", 64'(fetch_ready), 64'(1'b0));
    chk("o_wait_req", 64'(inst_req), 64'(1'b0));
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'hD000_0000;
    #1;
    chk("o_wait_ready2", 64'(fetch_ready), 64'(1'b0));
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk_resp("o_bus_first", 32'h7000, 32'hD000_0000, 3'b000);
    chk("o_exc_ready", 64'(fetch_ready), 64'(1'b1));
    tick();
    fetch_valid = 1'b0;
    inst_addr_ok = 1'b0;
    chk("o_gap", 64'(resp_valid), 64'(1'b0));
    tick();
    chk_resp("o_exc_second", 32'h7002, 32'h0, 3'b100);
    chk("o_busy_end", 64'(busy), 64'(1'b0));
    chk("o_proto_end", 64'(proto_err), 64'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
